alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled on a rising clk edge only in IDLE.
REQ-005 SHALL have port sel  input  2  operation: 00 add, 01 sub, 10 mul, 11 and.
REQ-006 SHALL have port A  input  WIDTH  unsigned operand A.
REQ-007 SHALL have port B  input  WIDTH  unsigned operand B.
REQ-008 SHALL have port Y  output  2*WIDTH  registered result.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking Y valid.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on start with sel=10, IDLE->DONE on start with any other sel; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-012 SHALL latch A, B, sel into internal registers on the accepting edge; input changes afterwards SHALL NOT affect the operation in flight.
REQ-013 add: Y = A + B zero-extended to 2*WIDTH; carry appears at Y[WIDTH].
REQ-014 sub: Y = A - B as a WIDTH+1-bit two's-complement result sign-extended to 2*WIDTH (e.g. WIDTH=4, 1-2 -> 8'hFF).
REQ-015 and: Y = A & B zero-extended to 2*WIDTH.
REQ-016 mul: unsigned shift-add, one partial-product bit per CALC cycle, iteration counter of ceil(log2(WIDTH+1)) bits; Y = A*B exact in 2*WIDTH bits.
REQ-017 Latency from accepting edge to done high: 1 cycle for add/sub/and; WIDTH+1 cycles for mul.
REQ-018 done SHALL be high exactly in DONE state; busy SHALL be high in CALC and DONE.
REQ-019 Y SHALL update only on entry to DONE and hold its value until the next DONE; intermediate mul partial products SHALL NOT be visible on Y.
REQ-020 start asserted while busy SHALL be ignored (no queuing); start held high continuously SHALL cause back-to-back operations with one IDLE cycle between them.
REQ-021 Operands 0 and all-ones SHALL give exact results with no wrap beyond 2*WIDTH bits (WIDTH=4: 15*15 = 8'hE1, 15+15 = 8'h1E).

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, Y=0, busy=0, done=0, counter=0, operand registers=0, regardless of clk.
REQ-023 rst_n asserted mid-operation SHALL abort it with no done pulse; first start after release is sampled on the first rising edge with rst_n high.

Configuration
REQ-024 Macro ALU_SEQ_FLAGS_EN: when defined, SHALL add outputs zero (1 bit, Y==0) and neg (1 bit, sub result negative, else 0), registered with Y, reset to 0; when undefined, these ports and their logic SHALL be absent and all other behaviour identical.

Verification (WIDTH=4)
REQ-025 Reset: rst_n=0 mid-mul -> Y=0, busy=0, done=0 asynchronously; no done pulse after release.
REQ-026 Add: A=3,B=2,sel=00,start pulse -> next cycle done=1, Y=8'h05; A=15,B=15 -> Y=8'h1E.
REQ-027 Sub/and: A=1,B=2,sel=01 -> Y=8'hFF (neg=1 if flags enabled); A=4'hA,B=4'h6,sel=11 -> Y=8'h02.
REQ-028 Mul: A=15,B=15,sel=10 -> busy for 5 cycles, done on 5th cycle after accept, Y=8'hE1; A=0 -> Y=0 (zero=1 if flags enabled).
REQ-029 Busy rules: start pulsed during mul with new operands -> ignored, Y still 8'hE1; start held high with sel=00 -> done every 2 cycles.
REQ-030 Exhaustive: all 16x16 A/B pairs for each sel, compared against a behavioural model at every done.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Small sequential ALU. add/sub/and finish in a single cycle
//            through a DONE state. mul is an unsigned shift-add multiplier
//            that runs one partial-product bit per CALC cycle.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - request, sampled only while IDLE
//            sel    - 00 add, 01 sub, 10 mul, 11 and
//            A, B   - unsigned WIDTH-bit operands
//            Y      - registered 2*WIDTH-bit result, held between operations
//            busy   - high whenever the FSM is not IDLE
//            done   - one-cycle pulse while Y is freshly valid
//            zero   - (ALU_SEQ_FLAGS_EN only) Y == 0, registered with Y
//            neg    - (ALU_SEQ_FLAGS_EN only) sub result negative
// Config   : define ALU_SEQ_FLAGS_EN to add the zero/neg flag outputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Y,
  output logic               busy,
`ifdef ALU_SEQ_FLAGS_EN
  output logic               zero,
  output logic               neg,
`endif
  output logic               done
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b10;
  localparam logic [1:0] c_OP_AND = 2'b11;

  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;      // shifted right as multiplier bits are consumed
  logic [1:0]         r_sel;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // private partial product, never drives Y

  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_fast;
  logic [2*WIDTH-1:0] w_term;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  // Single-cycle results come straight from the inputs on the accepting
  // edge, so Y is already valid when DONE is entered.
  assign w_diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    w_fast = '0;
    case (sel)
      c_OP_ADD: w_fast = {{(WIDTH-1){1'b0}}, ({1'b0, A} + {1'b0, B})};
      c_OP_SUB: w_fast = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
      c_OP_AND: w_fast = {{WIDTH{1'b0}}, (A & B)};
      default:  w_fast = '0;
    endcase
  end

  // Partial product for the multiplier bit currently at r_b[0].
  assign w_term     = r_b[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
  assign w_acc_next = r_acc + w_term;
  // Only mul ever occupies CALC; any other latched op leaves immediately.
  assign w_last     = (r_cnt == c_LAST) || (r_sel != c_OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      Y       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zero    <= 1'b0;
      neg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_sel <= sel;
            r_cnt <= '0;
            r_acc <= '0;
            if (sel == c_OP_MUL) begin
              r_state <= c_CALC;
            end else begin
              r_state <= c_DONE;
              Y       <= w_fast;
`ifdef ALU_SEQ_FLAGS_EN
              zero    <= (w_fast == '0);
              neg     <= (sel == c_OP_SUB) && w_diff[WIDTH];
`endif
            end
          end
        end
        c_CALC: begin
          r_acc <= w_acc_next;
          r_b   <= r_b >> 1;
          if (w_last) begin
            r_state <= c_DONE;
            r_cnt   <= '0;
            Y       <= w_acc_next;
`ifdef ALU_SEQ_FLAGS_EN
            zero    <= (w_acc_next == '0);
            neg     <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != c_IDLE);
  assign done = (r_state == c_DONE);

endmodule
`default_nettype wire
